// File: rtl/multiplexador_n_reg.sv
// Registered N:1 datapath multiplexer with valid/ready handshake.
// Channel choice is either a direct control-unit select or round-robin arbitration.
module multiplexador_n_reg #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SEL_W       = 2,
    parameter logic [31:0] OUT_DEFAULT = 32'h1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        UC_mode,
    input  logic [SEL_W-1:0]            UC_sel,
    input  logic [CHANNELS*WIDTH-1:0]   data_in,
    input  logic [CHANNELS-1:0]         in_valid,
    output logic [CHANNELS-1:0]         in_ready,
    output logic [WIDTH-1:0]            mult_out,
    output logic [SEL_W-1:0]            out_chan,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sel_err
);

    logic               load;
    logic               granted;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   ptr;
    logic [WIDTH-1:0]   grant_data;

    assign load = !out_valid || out_ready;

    always_comb begin
        grant   = '0;
        granted = 1'b0;
        if (!UC_mode) begin
            // An out-of-range select matches no channel, so it never grants.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (UC_sel == SEL_W'(i) && in_valid[i]) begin
                    grant   = SEL_W'(i);
                    granted = 1'b1;
                end
            end
        end else begin
            // Rotating search from ptr+1: lowest valid channel above ptr first,
            // otherwise wrap to the lowest valid channel at or below ptr.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!granted && SEL_W'(i) > ptr && in_valid[i]) begin
                    grant   = SEL_W'(i);
                    granted = 1'b1;
                end
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!granted && SEL_W'(i) <= ptr && in_valid[i]) begin
                    grant   = SEL_W'(i);
                    granted = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n && load && granted && (grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_out  <= WIDTH'(OUT_DEFAULT);
            out_chan  <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else begin
            sel_err <= !UC_mode && (32'(UC_sel) >= CHANNELS);
            if (load) begin
                if (granted) begin
                    mult_out  <= grant_data;
                    out_chan  <= grant;
                    out_valid <= 1'b1;
                    if (UC_mode) begin
                        ptr <= grant;
                    end
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplexador_n_reg.sv
// Self-checking bench for multiplexador_n_reg: directed scenarios plus
// randomized traffic against a queue-free behavioural arbitration model.
module tb_multiplexador_n_reg;

    logic           clk;
    logic           rst_n;

    // 4-channel instance (default parameters)
    logic           UC_mode;
    logic [1:0]     UC_sel;
    logic [127:0]   data_in;
    logic [3:0]     in_valid;
    logic [3:0]     in_ready;
    logic [31:0]    mult_out;
    logic [1:0]     out_chan;
    logic           out_valid;
    logic           out_ready;
    logic           sel_err;

    // 3-channel instance for the out-of-range select case
    logic           UC3_mode;
    logic [1:0]     UC3_sel;
    logic [95:0]    data3_in;
    logic [2:0]     in3_valid;
    logic [2:0]     in3_ready;
    logic [31:0]    mult3_out;
    logic [1:0]     out3_chan;
    logic           out3_valid;
    logic           out3_ready;
    logic           sel3_err;

    int checks;
    int errors;

    // behavioural model state
    logic [31:0] m_out;
    int          m_chan;
    logic        m_valid;
    int          m_ptr;
    logic        m_err;

    multiplexador_n_reg #(
        .WIDTH(32), .CHANNELS(4), .SEL_W(2), .OUT_DEFAULT(32'h1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .UC_mode(UC_mode), .UC_sel(UC_sel),
        .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .mult_out(mult_out), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    multiplexador_n_reg #(
        .WIDTH(32), .CHANNELS(3), .SEL_W(2), .OUT_DEFAULT(32'h1)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .UC_mode(UC3_mode), .UC_sel(UC3_sel),
        .data_in(data3_in), .in_valid(in3_valid), .in_ready(in3_ready),
        .mult_out(mult3_out), .out_chan(out3_chan), .out_valid(out3_valid),
        .out_ready(out3_ready), .sel_err(sel3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick();
        int c;
        if (!UC_mode) begin
            if (int'(UC_sel) < 4 && in_valid[UC_sel]) return int'(UC_sel);
            return -1;
        end
        for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        if (!rst_n) return 4'b0;
        if (m_valid && !out_ready) return 4'b0;
        g = pick();
        if (g < 0) return 4'b0;
        return 4'(1 << g);
    endfunction

    task automatic model_reset();
        m_out   = 32'h1;
        m_chan  = 0;
        m_valid = 1'b0;
        m_ptr   = 3;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        int g;
        m_err = !UC_mode && (int'(UC_sel) >= 4);
        if (!m_valid || out_ready) begin
            g = pick();
            if (g >= 0) begin
                m_out   = data_in[g*32 +: 32];
                m_chan  = g;
                m_valid = 1'b1;
                if (UC_mode) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; UC_mode = 1'b0; UC_sel = 2'd0;
        data_in = '0;
        UC3_mode = 1'b0; UC3_sel = 2'd0; data3_in = '0; in3_valid = 3'b0; out3_ready = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (mult_out !== 32'h1) begin errors++; $display("FAIL reset_mult_out got %h want %h", mult_out, 32'h1); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        checks++; if (out_chan !== 2'd0 || sel_err !== 1'b0) begin errors++; $display("FAIL reset_chan_err got %0d/%b want 0/0", out_chan, sel_err); end
        tick();
        rst_n = 1'b1;
        in_valid = 4'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_direct();
        UC_mode = 1'b0; UC_sel = 2'd2; out_ready = 1'b1;
        data_in[2*32 +: 32] = 32'hCAFE0002; in_valid = 4'b0100;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL direct_in_ready got %b want 0100", in_ready); end
        tick();
        in_valid = 4'b0;
        @(negedge clk);
        checks++; if (mult_out !== 32'hCAFE0002) begin errors++; $display("FAIL direct_data got %h want cafe0002", mult_out); end
        checks++; if (out_chan !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL direct_chan_valid got %0d/%b want 2/1", out_chan, out_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        UC_mode = 1'b0; UC_sel = 2'd1; out_ready = 1'b1;
        data_in[1*32 +: 32] = 32'h11110001; in_valid = 4'b0010;
        tick();
        out_ready = 1'b0;
        data_in[1*32 +: 32] = 32'h22220001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0 || mult_out !== 32'h11110001 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d got rdy=%b out=%h v=%b want rdy=0000 out=11110001 v=1", c, in_ready, mult_out, out_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL unstall_in_ready got %b want 0010", in_ready); end
        tick();
        in_valid = 4'b0;
        @(negedge clk);
        checks++; if (mult_out !== 32'h22220001 || out_valid !== 1'b1) begin errors++; $display("FAIL no_bubble got %h/%b want 22220001/1", mult_out, out_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        int seq_a[5] = '{0, 1, 2, 3, 0};
        int seq_b[4] = '{1, 3, 1, 3};
        pulse_reset();
        UC_mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        for (int i = 0; i < 4; i++) data_in[i*32 +: 32] = 32'hA0000000 + 32'(i);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checks++; if (out_chan !== 2'(seq_a[i]) || out_valid !== 1'b1) begin errors++; $display("FAIL rr_all step%0d got %0d want %0d", i, out_chan, seq_a[i]); end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            checks++; if (out_chan !== 2'(seq_b[i]) || mult_out !== 32'hA0000000 + 32'(seq_b[i])) begin errors++; $display("FAIL rr_1010 step%0d got %0d want %0d", i, out_chan, seq_b[i]); end
        end
        tick();
        in_valid = 4'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        UC3_mode = 1'b0; UC3_sel = 2'd0; in3_valid = 3'b111; out3_ready = 1'b1;
        data3_in[0 +: 32] = 32'h33330000;
        tick();
        out3_ready = 1'b0; UC3_sel = 2'd3;
        tick();
        @(negedge clk);
        checks++; if (sel3_err !== 1'b1) begin errors++; $display("FAIL oor_sel_err got %b want 1", sel3_err); end
        checks++; if (in3_ready !== 3'b0 || out3_valid !== 1'b1 || mult3_out !== 32'h33330000) begin errors++; $display("FAIL oor_held got rdy=%b v=%b out=%h want 000/1/33330000", in3_ready, out3_valid, mult3_out); end
        out3_ready = 1'b1;
        #1;
        checks++; if (in3_ready !== 3'b0) begin errors++; $display("FAIL oor_no_grant got %b want 000", in3_ready); end
        tick();
        @(negedge clk);
        checks++; if (out3_valid !== 1'b0 || sel3_err !== 1'b1) begin errors++; $display("FAIL oor_drain got v=%b err=%b want 0/1", out3_valid, sel3_err); end
        UC3_sel = 2'd0; in3_valid = 3'b0;
        tick();
    endtask

    task automatic test_mode_switch_reset();
        UC_mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
        data_in[2*32 +: 32] = 32'h5A5A0002;
        tick();
        out_ready = 1'b0; in_valid = 4'hF;
        tick();
        UC_mode = 1'b0; UC_sel = 2'd3;
        data_in[2*32 +: 32] = 32'h0BAD0002;
        tick();
        @(negedge clk);
        checks++; if (mult_out !== 32'h5A5A0002 || out_chan !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL mode_switch_hold got %h/%0d/%b want 5a5a0002/2/1", mult_out, out_chan, out_valid); end
        checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL mode_switch_stall got %b want 0000", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (out_valid !== 1'b0 || mult_out !== 32'h1 || in_ready !== 4'b0) begin errors++; $display("FAIL async_reset got v=%b out=%h rdy=%b want 0/00000001/0000", out_valid, mult_out, in_ready); end
        tick();
        rst_n = 1'b1;
        in_valid = 4'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_reissue got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            UC_mode   = 1'($urandom_range(0, 1));
            UC_sel    = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) data_in[i*32 +: 32] = $urandom();
            @(negedge clk);
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_in_ready cyc%0d got %b want %b", n, in_ready, exp_ready()); end
            checks++; if (mult_out !== m_out || out_chan !== 2'(m_chan) || out_valid !== m_valid) begin errors++; $display("FAIL rnd_output cyc%0d got %h/%0d/%b want %h/%0d/%b", n, mult_out, out_chan, out_valid, m_out, m_chan, m_valid); end
            checks++; if (sel_err !== m_err) begin errors++; $display("FAIL rnd_sel_err cyc%0d got %b want %b", n, sel_err, m_err); end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_direct();
        test_backpressure();
        test_round_robin();
        test_out_of_range();
        test_mode_switch_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplexador_n_reg.md
Name: multiplexador_n_reg

Overview:
- Parametrised, registered N:1 datapath multiplexer with valid/ready handshake.
- Successor to the fixed 4-input combinational mux driven by the control unit.
- Selects one of CHANNELS inputs, either by a direct control-unit select or by a round-robin arbitration mode, and registers the chosen word into a single-entry output stage with backpressure.
- Used between execution/memory sources and shared consumers (register-file write port, bus) in the processor datapath.

Parameters:
- WIDTH, 32, data word width in bits.
- CHANNELS, 4, number of input channels; must be >= 2.
- SEL_W, 2, select width; must equal clog2(CHANNELS).
- OUT_DEFAULT, 32'h1, reset value of mult_out (zero-extended or truncated to WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- UC_mode  input  1  0 = direct select, 1 = round-robin.
- UC_sel  input  SEL_W  channel index used in direct mode.
- data_in  input  CHANNELS*WIDTH  packed inputs; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel word-available flag.
- in_ready  output  CHANNELS  per-channel accept strobe; one-hot or zero.
- mult_out  output  WIDTH  registered selected word.
- out_chan  output  SEL_W  channel index that produced mult_out.
- out_valid  output  1  mult_out holds an unconsumed beat.
- out_ready  input  1  consumer accepts the beat this cycle.
- sel_err  output  1  registered flag: direct select out of range (UC_sel >= CHANNELS).

Behaviour:
- Reset (rst_n low, asynchronous):
  - mult_out = OUT_DEFAULT, out_chan = 0, out_valid = 0, sel_err = 0.
  - RR pointer = CHANNELS-1, so channel 0 has first priority.
  - in_ready forced to 0 while rst_n is low.
- Load enable: load = !out_valid || out_ready (combinational). This gives full throughput of 1 beat/cycle.
- Grant, direct mode (UC_mode=0):
  - grant = UC_sel, granted only if UC_sel < CHANNELS and in_valid[UC_sel].
- Grant, round-robin mode (UC_mode=1):
  - Search channels starting at ptr+1, wrapping modulo CHANNELS.
  - Grant the first channel with in_valid set.
  - No valid input means no grant.
- in_ready[i] = load && granted && grant==i; all other bits are 0.
- Transfer happens when in_ready[i] && in_valid[i]. On the next edge:
  - mult_out <= data_in[i], out_chan <= i, out_valid <= 1.
  - In RR mode, ptr <= i. In direct mode, ptr is unchanged.
- Latency: input accepted at edge k appears on mult_out with out_valid=1 after edge k (1 cycle).
- Load without grant: out_valid <= 0; mult_out and out_chan hold their last value.
- Stall (out_valid && !out_ready): mult_out, out_chan, out_valid hold; all in_ready = 0; no input is consumed.
- sel_err <= (UC_mode==0 && UC_sel >= CHANNELS), updated every cycle regardless of load. An out-of-range select never produces a beat. sel_err is constant 0 when CHANNELS == 2**SEL_W.
- Mode switch:
  - Takes effect on the next grant decision.
  - Does not disturb a held output beat.
  - ptr is retained across mode changes.
- Simultaneous consume and load: when out_ready=1 and a grant exists in the same cycle, the old beat is consumed and the new beat is loaded on the same edge, with no bubble.
- Reset mid-transfer: the held beat is discarded and nothing is reissued.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'hF -> mult_out=32'h1, out_valid=0, in_ready=0. Release -> first cycle behaves per mode.
- Direct select: UC_mode=0, UC_sel=2, data_in ch2=32'hCAFE0002, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle mult_out=32'hCAFE0002, out_chan=2, out_valid=1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with new valid input -> in_ready=0, mult_out stable. out_ready=1 -> new word loaded same edge, no bubble.
- Round-robin fairness: UC_mode=1, in_valid=4'hF constant, out_ready=1 -> out_chan sequence 0,1,2,3,0. With in_valid=4'b1010 -> out_chan sequence 1,3,1,3.
- Out of range: CHANNELS=3, SEL_W=2, UC_mode=0, UC_sel=3 -> sel_err=1 next cycle, in_ready=0, out_valid falls to 0 after the held beat is consumed.
- Mode switch and async reset mid-stall: switch UC_mode 1->0 while stalled -> held beat unchanged. Assert rst_n low mid-stall -> out_valid=0 immediately, without waiting for a clock edge.
